// File: rtl/adc_seven_segment_display_pkg.sv
// Shared types and constants for the ADC seven-segment display.
//   - mode_e       : display format code as delivered with the ADC result
//   - SEG_BLANK    : all segments off (active-low cathodes)
//   - SEG_DASH     : only segment g lit, used for invalid BCD nibbles
//   - HEX_GLYPH    : 16-entry glyph table, bit order {g,f,e,d,c,b,a}, active-low
package adc_display_pkg;

    localparam int unsigned VALUE_W = 16;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned MODE_W  = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HEX  = 2'b00,
        MODE_BCD  = 2'b01,
        MODE_VOLT = 2'b10,
        MODE_HEX2 = 2'b11
    } mode_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

    // Glyph lookup for one nibble.
    function automatic logic [SEG_W-1:0] hex_glyph(input logic [NIB_W-1:0] nib);
        return HEX_GLYPH[nib];
    endfunction

endpackage

// File: rtl/adc_seven_segment_display_if.sv
// Bus between the ADC result source and the display block.
//   adc_value      : 16-bit conversion result (binary or packed BCD)
//   bin_bcd_select : display mode code
//   hold           : freeze the displayed snapshot while high
//   anode          : digit enables, active-low, anode[0] = rightmost
//   cathode        : segments {g,f,e,d,c,b,a}, active-low
//   dp             : decimal point, active-low
// master = result source / bench, slave = display block.
interface adc_seven_segment_display_if;
    import adc_display_pkg::*;

    logic [VALUE_W-1:0] adc_value;
    logic [MODE_W-1:0]  bin_bcd_select;
    logic               hold;
    logic [DIGITS-1:0]  anode;
    logic [SEG_W-1:0]   cathode;
    logic               dp;

    modport master (
        output adc_value, bin_bcd_select, hold,
        input  anode, cathode, dp
    );

    modport slave (
        input  adc_value, bin_bcd_select, hold,
        output anode, cathode, dp
    );

endinterface

// File: rtl/adc_seven_segment_display_seg7_decoder.sv
// Combinational nibble-to-segment decoder.
//   nibble    : 4-bit digit value
//   blank     : force all segments off (takes priority over dash)
//   dash      : show a dash instead of the glyph
//   cathode_c : active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
    import adc_display_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    input  logic             blank,
    input  logic             dash,
    output logic [SEG_W-1:0] cathode_c
);

    always_comb begin
        cathode_c = hex_glyph(nibble);
        if (blank) begin
            cathode_c = SEG_BLANK;
        end else if (dash) begin
            cathode_c = SEG_DASH;
        end
    end

endmodule

// File: rtl/adc_seven_segment_display.sv
// Four-digit multiplexed common-anode display for the SAR ADC result.
// Snapshots value+mode every UPDATE_DIV clocks (unless held), scans one digit
// per SCAN_DIV clocks with a one-cycle blanked gap after each digit change,
// and formats as hex, zero-blanked BCD or X.XXX volts.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of adc_seven_segment_display_if
module adc_seven_segment_display
    import adc_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter int unsigned UPDATE_DIV = 25_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    adc_seven_segment_display_if.slave   bus
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int unsigned UPD_W  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    logic [SCAN_W-1:0]  scan_cnt_q,     scan_cnt_d;
    logic [UPD_W-1:0]   upd_cnt_q,      upd_cnt_d;
    logic [IDX_W-1:0]   idx_q,          idx_d;
    logic               idx_changed_q,  idx_changed_d;
    logic               load_pending_q, load_pending_d;
    logic [VALUE_W-1:0] snap_value_q,   snap_value_d;
    mode_e              snap_mode_q,    snap_mode_d;
    logic [DIGITS-1:0]  anode_q,        anode_d;
    logic [SEG_W-1:0]   cathode_q,      cathode_d;
    logic               dp_q,           dp_d;

    logic               scan_wrap_c;
    logic               upd_wrap_c;
    logic               load_c;
    logic [NIB_W-1:0]   nibble_c;
    logic [DIGITS-1:0]  nib_zero_c;
    logic [DIGITS-1:0]  lead_zero_c;
    logic               blank_c;
    logic               dash_c;
    logic [SEG_W-1:0]   seg_c;

    // Counters, snapshot control and digit formatting.
    always_comb begin
        scan_wrap_c    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        upd_wrap_c     = (upd_cnt_q == UPD_W'(UPDATE_DIV - 1));
        scan_cnt_d     = scan_wrap_c ? '0 : scan_cnt_q + SCAN_W'(1);
        upd_cnt_d      = upd_wrap_c  ? '0 : upd_cnt_q + UPD_W'(1);
        idx_d          = scan_wrap_c ? idx_q + IDX_W'(1) : idx_q;
        idx_changed_d  = scan_wrap_c;

        // A wrap re-arms the flag even on the cycle that consumes it.
        load_c         = load_pending_q & ~bus.hold;
        load_pending_d = upd_wrap_c | (load_pending_q & ~load_c);
        snap_value_d   = snap_value_q;
        snap_mode_d    = snap_mode_q;
        if (load_c) begin
            snap_value_d = bus.adc_value;
            snap_mode_d  = mode_e'(bus.bin_bcd_select);
        end

        nibble_c = snap_value_q[{idx_q, 2'b00} +: NIB_W];
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib_zero_c[i] = (snap_value_q[i*NIB_W +: NIB_W] == '0);
        end

        // A digit is a leading zero if it and everything to its left is zero.
        lead_zero_c[3] = nib_zero_c[3];
        lead_zero_c[2] = nib_zero_c[3] & nib_zero_c[2];
        lead_zero_c[1] = nib_zero_c[3] & nib_zero_c[2] & nib_zero_c[1];
        lead_zero_c[0] = 1'b0;

        blank_c = (snap_mode_q == MODE_BCD) && lead_zero_c[idx_q];
        dash_c  = ((snap_mode_q == MODE_BCD) || (snap_mode_q == MODE_VOLT))
                  && (nibble_c > NIB_W'(9));

        // Blank all anodes for one cycle after a digit change to avoid ghosting.
        anode_d   = idx_changed_q ? '1 : ~(DIGITS'(1) << idx_q);
        cathode_d = seg_c;
        dp_d      = ~((snap_mode_q == MODE_VOLT) && (idx_q == IDX_W'(3))
                      && !idx_changed_q);
    end

    seg7_decoder u_seg7_decoder (
        .nibble    (nibble_c),
        .blank     (blank_c),
        .dash      (dash_c),
        .cathode_c (seg_c)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q     <= '0;
            upd_cnt_q      <= '0;
            idx_q          <= '0;
            idx_changed_q  <= 1'b0;
            load_pending_q <= 1'b1;
            snap_value_q   <= '0;
            snap_mode_q    <= MODE_HEX;
            anode_q        <= '1;
            cathode_q      <= SEG_BLANK;
            dp_q           <= 1'b1;
        end else begin
            scan_cnt_q     <= scan_cnt_d;
            upd_cnt_q      <= upd_cnt_d;
            idx_q          <= idx_d;
            idx_changed_q  <= idx_changed_d;
            load_pending_q <= load_pending_d;
            snap_value_q   <= snap_value_d;
            snap_mode_q    <= snap_mode_d;
            anode_q        <= anode_d;
            cathode_q      <= cathode_d;
            dp_q           <= dp_d;
        end
    end

    assign bus.anode   = anode_q;
    assign bus.cathode = cathode_q;
    assign bus.dp      = dp_q;

endmodule

// File: tb/tb_adc_seven_segment_display.sv
// Directed bench for adc_seven_segment_display with SCAN_DIV=4, UPDATE_DIV=32.
module tb_adc_seven_segment_display;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    adc_seven_segment_display_if bus ();

    adc_seven_segment_display #(
        .SCAN_DIV   (4),
        .UPDATE_DIV (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_anode"},   16'(bus.anode),   16'h000F);
        chk({tag, "_cathode"}, 16'(bus.cathode), 16'h007F);
        chk({tag, "_dp"},      16'(bus.dp),      16'h0001);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            chk_reset_state("rst");
        end
        reset = 1'b0;
    endtask

    // Step until the blanked gap cycle; a missed gap is a failed comparison.
    task automatic wait_ghost(input string tag);
        int n;
        n = 0;
        while (bus.anode !== 4'b1111 && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_gap_anode"}, 16'(bus.anode), 16'h000F);
        chk({tag, "_gap_dp"},    16'(bus.dp),    16'h0001);
    endtask

    // From reset release: first cycle shows digit 0 of the zero snapshot,
    // then each digit of the new snapshot, each later one preceded by a gap.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        logic [3:0] an;
        step();
        chk({tag, "_first_anode"},   16'(bus.anode),   16'h000E);
        chk({tag, "_first_cathode"}, 16'(bus.cathode), 16'h0040);
        step();
        chk({tag, "_d0_anode"},   16'(bus.anode),   16'h000E);
        chk({tag, "_d0_cathode"}, 16'(bus.cathode), 16'(segs[6:0]));
        chk({tag, "_d0_dp"},      16'(bus.dp),      16'(dps[0]));
        for (int d = 1; d < 4; d++) begin
            wait_ghost(tag);
            step();
            an = ~(4'b0001 << d);
            chk($sformatf("%s_d%0d_anode", tag, d),   16'(bus.anode),   16'(an));
            chk($sformatf("%s_d%0d_cathode", tag, d), 16'(bus.cathode), 16'(segs[d*7 +: 7]));
            chk($sformatf("%s_d%0d_dp", tag, d),      16'(bus.dp),      16'(dps[d]));
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] val, input logic [1:0] mode,
                             input logic [27:0] segs, input logic [3:0] dps);
        bus.adc_value      = val;
        bus.bin_bcd_select = mode;
        bus.hold           = 1'b0;
        apply_reset(1);
        check_frame(tag, segs, dps);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.adc_value      = 16'h1A2F;
        bus.bin_bcd_select = 2'b00;
        bus.hold           = 1'b0;

        // Reset held 3 cycles, then hex 1A2F: F, 2, A, 1.
        apply_reset(3);
        check_frame("hex", {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110}, 4'b1111);

        // Mode 11 is also hex: BCDE -> E, d, C, b.
        run_frame("hex2", 16'hBCDE, 2'b11,
                  {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}, 4'b1111);

        // BCD 0042: two leading blanks, 4, 2.
        run_frame("bcd42", 16'h0042, 2'b01,
                  {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100}, 4'b1111);

        // BCD 0000: only digit 0 shows 0.
        run_frame("bcd0", 16'h0000, 2'b01,
                  {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111);

        // Volts 3300: 3.300, dp on leftmost digit only, no blanking.
        run_frame("volt", 16'h3300, 2'b10,
                  {7'b0110000, 7'b0110000, 7'b1000000, 7'b1000000}, 4'b0111);

        // Invalid BCD 00A5: digit 1 dash, upper digits blanked.
        run_frame("bcdA5", 16'h00A5, 2'b01,
                  {7'b1111111, 7'b1111111, 7'b0111111, 7'b0010010}, 4'b1111);

        // Hold: snapshot of 1111 stays through 3 update periods.
        bus.adc_value      = 16'h1111;
        bus.bin_bcd_select = 2'b00;
        bus.hold           = 1'b0;
        apply_reset(1);
        step();
        step();
        chk("hold_pre", 16'(bus.cathode), 16'h0079);
        bus.hold      = 1'b1;
        bus.adc_value = 16'h2222;
        for (int k = 0; k < 12; k++) begin
            repeat (8) step();
            chk($sformatf("hold_%0d", k), 16'(bus.cathode), 16'h0079);
        end
        bus.hold = 1'b0;
        step();
        chk("hold_rel1", 16'(bus.cathode), 16'h0079);
        step();
        chk("hold_rel2", 16'(bus.cathode), 16'h0024);

        // Reset mid-slot at index 2, scan count 1.
        bus.adc_value      = 16'h1A2F;
        bus.bin_bcd_select = 2'b00;
        apply_reset(1);
        repeat (8) step();
        chk("mid_idx1", 16'(bus.anode), 16'h000D);
        step();
        chk("mid_gap", 16'(bus.anode), 16'h000F);
        reset = 1'b1;
        step();
        chk_reset_state("mid_rst");
        reset = 1'b0;
        step();
        chk("mid_rel_anode",   16'(bus.anode),   16'h000E);
        chk("mid_rel_cathode", 16'(bus.cathode), 16'h0040);
        step();
        chk("mid_new_cathode", 16'(bus.cathode), 16'h000E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_seven_segment_display.md
# adc_seven_segment_display

Downstream consumer of the SAR ADC subsystem's 16-bit conversion result and its 2-bit `bin_bcd_select` format code. It drives a 4-digit common-anode seven-segment display. The block snapshots the result at a slow, flicker-free rate and time-multiplexes the four digits. It also applies the format rules: hex, decimal with leading-zero blanking, or volts with a decimal point.

## Interface
- `SCAN_DIV`, default 100_000: clocks per digit slot (1 kHz slot rate, 250 Hz frame at 100 MHz).
- `UPDATE_DIV`, default 25_000_000: clocks between value snapshots (4 Hz).
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `adc_value` in 16: conversion result. Binary in mode 00/11, packed BCD in 01/10.
- `bin_bcd_select` in 2: display mode.
  - 00: hex.
  - 01: BCD with leading-zero blanking.
  - 10: BCD volts, shown as `X.XXX`.
  - 11: hex.
- `hold` in 1: freezes the displayed snapshot while high.
- `anode` out 4: digit enables, active-low. `anode[0]` is the rightmost digit.
- `cathode` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- **Snapshot register (16-bit value, 2-bit mode).**
  - A `load_pending` flag is set by reset and by every update-counter wrap (count == `UPDATE_DIV-1` → 0).
  - On any cycle with `load_pending`=1 and `hold`=0, the register captures `adc_value` and `bin_bcd_select`, and the flag clears.
  - While `hold`=1, the flag stays set. The load happens on the first cycle after `hold` falls.
- **Scan counter and digit index.**
  - The scan counter wraps at `SCAN_DIV-1`. On the wrap cycle the 2-bit digit index increments: 0→1→2→3→0.
- **Digit selection.** Nibble = snapshot[4i+3:4i] for index i.
- **Decode per mode.**
  - 00/11: hex glyphs 0-F (`0`=1000000, `1`=1111001, `2`=0100100, `3`=0110000, `4`=0011001, `5`=0010010, `6`=0000010, `7`=1111000, `8`=0000000, `9`=0010000, `A`=0001000, `b`=0000011, `C`=1000110, `d`=0100001, `E`=0000110, `F`=0001110). No blanking; `dp` off.
  - 01: nibbles >9 show dash (0111111). Digit i (i≥1) is blanked (1111111) if it and every digit to its left are zero. Digit 0 is never blanked. `dp` off.
  - 10: same nibble>9 → dash rule, no blanking. `dp`=0 only while index=3.
- **Ghost suppression.** On the cycle following a digit-index change, `anode` is forced to 4'b1111. The new digit is enabled on the next cycle.

## Timing
- **During reset:**
  - `anode`=1111, `cathode`=1111111, `dp`=1.
  - Counters, index, snapshot and mode are all 0.
  - `load_pending`=1.
- **Output latency.** Outputs are registered with 1-clock latency from index/snapshot.
- **First cycle after reset release:**
  - Snapshot loads (if `hold`=0).
  - Outputs show digit 0 of the old (zero) snapshot: `anode`=1110, `cathode`=1000000.
  - The new value appears on the following cycle.
- **Digit slot.** Each slot is `SCAN_DIV` clocks: 1 blanked + `SCAN_DIV-1` lit. `SCAN_DIV`≥2 is required.
- **Coherence.** The snapshot only changes on a load cycle. Value and mode always change together, so a frame never mixes modes.
- **Simultaneous events.** If an update wrap and a scan wrap fall on the same cycle, both take effect. The displayed digit uses the new snapshot from the next cycle.
- **Reset mid-scan.** Reset returns to the reset state immediately, in the same cycle's register update, regardless of counter values.
- **Input changes.** Changes of `adc_value` between loads have no effect.

## Structure
- **Package `adc_display_pkg`:**
  - Mode enum: `MODE_HEX`, `MODE_BCD`, `MODE_VOLT`, `MODE_HEX2`.
  - Segment constants: `SEG_BLANK`, `SEG_DASH`.
  - The 16-entry hex glyph table.
- **Sub-module `seg7_decoder`:** combinational, 4-bit nibble + blank + dash → 7-bit cathode.
- **Top level:** counters, snapshot, blanking logic, output registers.
- **Counters.** Counter widths are `$clog2` of the parameters. Counters are internal rather than `integer_divider`, because that divider has no reset.

## Test plan
Bench parameters: `SCAN_DIV`=4, `UPDATE_DIV`=32.
- **Reset.** Hold `reset` 3 cycles → `anode`=1111, `cathode`=1111111, `dp`=1 throughout. After release: `anode`=1110 one cycle later, with the new snapshot the cycle after.
- **Hex mode.** Mode 00, value 16'h1A2F → over one frame, digits 0..3 show 0001110 (F), 0100100 (2), 0001000 (A), 1111001 (1). Each slot is preceded by one `anode`=1111 cycle.
- **Decimal blanking.** Mode 01, value 16'h0042 → digits 3,2 show 1111111, digit 1 shows 0011001, digit 0 shows 0100100. Value 16'h0000 → only digit 0 lit, showing `0`.
- **Volts mode.** Mode 10, value 16'h3300 → `dp`=0 only while `anode`=0111. Digits read 3,3,0,0 with no blanking. Invalid BCD 16'h00A5 in mode 01 → digit 1 shows dash 0111111.
- **Hold.** With `hold`=1, change `adc_value` 16'h1111→16'h2222 and run 3 update periods → display stays 1111. Drop `hold` → 2222 appears 2 cycles later.
- **Reset mid-slot.** Assert `reset` at index 2, scan count 1 → next cycle is in the reset state. After release, scanning restarts at digit 0.
